// File: rtl/ttt_turn_sequencer.sv
// Tic-tac-toe turn sequencer: owns the board, alternates player and AI moves, detects win/draw.
// Optional AI timeout fallback is built when TTT_AI_TIMEOUT_EN is defined.
module ttt_turn_sequencer #(
  parameter int AI_SETTLE  = 2,
  parameter int AI_TIMEOUT = 8,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic        p_valid,
  input  logic [3:0]  p_pos,
  output logic        p_ready,
  input  logic        ai_valid,
  input  logic [3:0]  ai_pos,
  output logic [17:0] board,
  output logic        ai_turn,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic        illegal,
  output logic        ai_err,
  output logic        fallback
);

  typedef enum logic [2:0] {
    S_P_TURN,
    S_EVAL_P,
    S_AI_WAIT,
    S_AI_SAMPLE,
    S_EVAL_AI,
    S_OVER
  } state_t;

  localparam logic [1:0] MARK_PLAYER = 2'b01;
  localparam logic [1:0] MARK_AI     = 2'b10;
  localparam logic [1:0] WIN_NONE    = 2'b00;
  localparam logic [1:0] WIN_DRAW    = 2'b11;

  if ((AI_SETTLE >= (1 << CNT_W)) || (AI_TIMEOUT > (1 << CNT_W))) begin : g_cnt_w_check
    $error("CNT_W too narrow for AI_SETTLE/AI_TIMEOUT");
  end

  // Positions outside 1..9 read back as occupied so they fail the legality test.
  function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] pos);
    cell_of = 2'b11;
    for (int k = 1; k <= 9; k++) begin
      if (pos == 4'(k)) cell_of = b[2*(k-1) +: 2];
    end
  endfunction

  function automatic logic [17:0] with_cell(input logic [17:0] b, input logic [3:0] pos,
                                            input logic [1:0] mark);
    with_cell = b;
    for (int k = 1; k <= 9; k++) begin
      if (pos == 4'(k)) with_cell[2*(k-1) +: 2] = mark;
    end
  endfunction

  function automatic logic has_line(input logic [17:0] b, input logic [1:0] mark);
    logic [9:1] h;
    for (int k = 1; k <= 9; k++) h[k] = (b[2*(k-1) +: 2] == mark);
    has_line = (h[1] & h[2] & h[3]) | (h[4] & h[5] & h[6]) | (h[7] & h[8] & h[9]) |
               (h[1] & h[4] & h[7]) | (h[2] & h[5] & h[8]) | (h[3] & h[6] & h[9]) |
               (h[1] & h[5] & h[9]) | (h[3] & h[5] & h[7]);
  endfunction

  function automatic logic is_full(input logic [17:0] b);
    is_full = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      if (b[2*(k-1) +: 2] == 2'b00) is_full = 1'b0;
    end
  endfunction

`ifdef TTT_AI_TIMEOUT_EN
  function automatic logic [3:0] lowest_empty(input logic [17:0] b);
    lowest_empty = 4'd0;
    for (int k = 9; k >= 1; k--) begin
      if (b[2*(k-1) +: 2] == 2'b00) lowest_empty = 4'(k);
    end
  endfunction
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [17:0]      r_board;
  logic [17:0]      w_board_nxt;
  logic [1:0]       r_winner;
  logic [1:0]       w_winner_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_illegal;
  logic             w_illegal_nxt;
  logic             r_ai_err;
  logic             w_ai_err_nxt;
`ifdef TTT_AI_TIMEOUT_EN
  logic             r_fallback;
  logic             w_fallback_nxt;
`endif
  logic             w_p_legal;
  logic             w_ai_legal;

  assign w_p_legal  = (cell_of(r_board, p_pos) == 2'b00);
  assign w_ai_legal = (cell_of(r_board, ai_pos) == 2'b00);

  always_comb begin
    w_state_nxt   = r_state;
    w_board_nxt   = r_board;
    w_winner_nxt  = r_winner;
    w_cnt_nxt     = r_cnt;
    w_illegal_nxt = 1'b0;
    w_ai_err_nxt  = 1'b0;
`ifdef TTT_AI_TIMEOUT_EN
    w_fallback_nxt = 1'b0;
`endif
    if (new_game) begin
      w_state_nxt  = S_P_TURN;
      w_board_nxt  = '0;
      w_winner_nxt = WIN_NONE;
      w_cnt_nxt    = '0;
    end else begin
      case (r_state)
        S_P_TURN: begin
          if (p_valid) begin
            if (w_p_legal) begin
              w_board_nxt = with_cell(r_board, p_pos, MARK_PLAYER);
              w_state_nxt = S_EVAL_P;
            end else begin
              w_illegal_nxt = 1'b1;
            end
          end
        end
        S_EVAL_P: begin
          if (has_line(r_board, MARK_PLAYER)) begin
            w_winner_nxt = MARK_PLAYER;
            w_state_nxt  = S_OVER;
          end else if (is_full(r_board)) begin
            w_winner_nxt = WIN_DRAW;
            w_state_nxt  = S_OVER;
          end else begin
            w_cnt_nxt   = CNT_W'(AI_SETTLE);
            w_state_nxt = S_AI_WAIT;
          end
        end
        // The AI needs a few cycles to see the new board before its suggestion is trusted.
        S_AI_WAIT: begin
          if (r_cnt <= CNT_W'(1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_AI_SAMPLE;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        S_AI_SAMPLE: begin
          if (ai_valid && w_ai_legal) begin
            w_board_nxt = with_cell(r_board, ai_pos, MARK_AI);
            w_cnt_nxt   = '0;
            w_state_nxt = S_EVAL_AI;
          end else begin
            w_ai_err_nxt = ai_valid;
`ifdef TTT_AI_TIMEOUT_EN
            if (r_cnt >= CNT_W'(AI_TIMEOUT - 1)) begin
              w_board_nxt    = with_cell(r_board, lowest_empty(r_board), MARK_AI);
              w_fallback_nxt = 1'b1;
              w_cnt_nxt      = '0;
              w_state_nxt    = S_EVAL_AI;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
`endif
          end
        end
        S_EVAL_AI: begin
          if (has_line(r_board, MARK_AI)) begin
            w_winner_nxt = MARK_AI;
            w_state_nxt  = S_OVER;
          end else if (is_full(r_board)) begin
            w_winner_nxt = WIN_DRAW;
            w_state_nxt  = S_OVER;
          end else begin
            w_state_nxt = S_P_TURN;
          end
        end
        S_OVER: begin
          w_state_nxt = S_OVER;
        end
        default: begin
          w_state_nxt = S_P_TURN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_P_TURN;
      r_board   <= '0;
      r_winner  <= WIN_NONE;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_ai_err  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_board   <= w_board_nxt;
      r_winner  <= w_winner_nxt;
      r_cnt     <= w_cnt_nxt;
      r_illegal <= w_illegal_nxt;
      r_ai_err  <= w_ai_err_nxt;
    end
  end

`ifdef TTT_AI_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_fallback <= 1'b0;
    else       r_fallback <= w_fallback_nxt;
  end
  assign fallback = r_fallback;
`else
  assign fallback = 1'b0;
`endif

  assign board     = r_board;
  assign winner    = r_winner;
  assign illegal   = r_illegal;
  assign ai_err    = r_ai_err;
  assign p_ready   = (r_state == S_P_TURN);
  assign ai_turn   = (r_state == S_AI_WAIT) || (r_state == S_AI_SAMPLE);
  assign game_over = (r_state == S_OVER);

endmodule

// File: tb/tb_ttt_turn_sequencer.sv
// Directed bench for ttt_turn_sequencer: turn flow, illegal moves, win/draw, AI errors, resets.
module tb_ttt_turn_sequencer;

  logic        clk;
  logic        reset;
  logic        new_game;
  logic        p_valid;
  logic [3:0]  p_pos;
  logic        p_ready;
  logic        ai_valid;
  logic [3:0]  ai_pos;
  logic [17:0] board;
  logic        ai_turn;
  logic        game_over;
  logic [1:0]  winner;
  logic        illegal;
  logic        ai_err;
  logic        fallback;

  int n_checks = 0;
  int n_fail   = 0;

  ttt_turn_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .new_game  (new_game),
    .p_valid   (p_valid),
    .p_pos     (p_pos),
    .p_ready   (p_ready),
    .ai_valid  (ai_valid),
    .ai_pos    (ai_pos),
    .board     (board),
    .ai_turn   (ai_turn),
    .game_over (game_over),
    .winner    (winner),
    .illegal   (illegal),
    .ai_err    (ai_err),
    .fallback  (fallback)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic play(input int pos);
    p_valid = 1'b1;
    p_pos   = 4'(pos);
    tick;
    p_valid = 1'b0;
  endtask

  // Starts in EVAL_P, ends one edge after EVAL_AI.
  task automatic ai_reply(input int pos);
    ai_valid = 1'b1;
    ai_pos   = 4'(pos);
    repeat (4) tick;
    ai_valid = 1'b0;
    tick;
  endtask

  task automatic start_new_game;
    new_game = 1'b1;
    tick;
    new_game = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (board !== 18'h0) begin n_fail++; $display("FAIL reset_board got=%h exp=%h", board, 18'h0); end
    n_checks++; if (p_ready !== 1'b1) begin n_fail++; $display("FAIL reset_p_ready got=%b exp=1", p_ready); end
    n_checks++; if (ai_turn !== 1'b0) begin n_fail++; $display("FAIL reset_ai_turn got=%b exp=0", ai_turn); end
    n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL reset_game_over got=%b exp=0", game_over); end
    n_checks++; if (winner !== 2'b00) begin n_fail++; $display("FAIL reset_winner got=%b exp=00", winner); end
    n_checks++; if ({illegal, ai_err, fallback} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses got=%b exp=000", {illegal, ai_err, fallback}); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_basic_turn;
    ai_valid = 1'b1;
    ai_pos   = 4'd1;
    play(5);
    n_checks++; if (board !== 18'h00100) begin n_fail++; $display("FAIL basic_p_write got=%h exp=%h", board, 18'h00100); end
    n_checks++; if (p_ready !== 1'b0) begin n_fail++; $display("FAIL basic_eval_p_ready got=%b exp=0", p_ready); end
    tick;
    n_checks++; if (ai_turn !== 1'b1) begin n_fail++; $display("FAIL basic_ai_wait got=%b exp=1", ai_turn); end
    tick;
    tick;
    n_checks++; if (board !== 18'h00100) begin n_fail++; $display("FAIL basic_no_early_ai got=%h exp=%h", board, 18'h00100); end
    tick;
    n_checks++; if (board !== 18'h00102) begin n_fail++; $display("FAIL basic_ai_write got=%h exp=%h", board, 18'h00102); end
    n_checks++; if (ai_turn !== 1'b0) begin n_fail++; $display("FAIL basic_eval_ai_turn got=%b exp=0", ai_turn); end
    ai_valid = 1'b0;
    tick;
    n_checks++; if (p_ready !== 1'b1) begin n_fail++; $display("FAIL basic_p_ready_back got=%b exp=1", p_ready); end
  endtask

  task automatic test_illegal;
    int vec [5] = '{5, 1, 0, 12, 10};
    for (int i = 0; i < 5; i++) begin
      play(vec[i]);
      n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse pos=%0d got=%b exp=1", vec[i], illegal); end
      n_checks++; if (board !== 18'h00102) begin n_fail++; $display("FAIL illegal_board pos=%0d got=%h exp=%h", vec[i], board, 18'h00102); end
      n_checks++; if (p_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_p_ready pos=%0d got=%b exp=1", vec[i], p_ready); end
    end
    tick;
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_clears got=%b exp=0", illegal); end
  endtask

  task automatic test_player_win;
    start_new_game;
    play(1);
    ai_reply(5);
    n_checks++; if (board !== 18'h00201) begin n_fail++; $display("FAIL pwin_mid_board got=%h exp=%h", board, 18'h00201); end
    play(2);
    ai_reply(9);
    play(3);
    tick;
    n_checks++; if (winner !== 2'b01) begin n_fail++; $display("FAIL pwin_winner got=%b exp=01", winner); end
    n_checks++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL pwin_game_over got=%b exp=1", game_over); end
    n_checks++; if (board !== 18'h20215) begin n_fail++; $display("FAIL pwin_board got=%h exp=%h", board, 18'h20215); end
    p_valid = 1'b1; p_pos = 4'd4; ai_valid = 1'b1; ai_pos = 4'd6;
    repeat (3) tick;
    p_valid = 1'b0; ai_valid = 1'b0;
    n_checks++; if (board !== 18'h20215) begin n_fail++; $display("FAIL over_frozen_board got=%h exp=%h", board, 18'h20215); end
    n_checks++; if ({illegal, ai_err} !== 2'b00) begin n_fail++; $display("FAIL over_no_pulses got=%b exp=00", {illegal, ai_err}); end
    n_checks++; if (winner !== 2'b01) begin n_fail++; $display("FAIL over_frozen_winner got=%b exp=01", winner); end
    start_new_game;
    n_checks++; if (board !== 18'h0) begin n_fail++; $display("FAIL newgame_board got=%h exp=0", board); end
    n_checks++; if (winner !== 2'b00) begin n_fail++; $display("FAIL newgame_winner got=%b exp=00", winner); end
    n_checks++; if ({p_ready, game_over} !== 2'b10) begin n_fail++; $display("FAIL newgame_state got=%b exp=10", {p_ready, game_over}); end
  endtask

  task automatic test_draw;
    start_new_game;
    play(1); ai_reply(2);
    play(3); ai_reply(5);
    play(4); ai_reply(7);
    play(8); ai_reply(6);
    play(9);
    n_checks++; if (board !== 18'h16A59) begin n_fail++; $display("FAIL draw_board got=%h exp=%h", board, 18'h16A59); end
    tick;
    n_checks++; if (winner !== 2'b11) begin n_fail++; $display("FAIL draw_winner got=%b exp=11", winner); end
    n_checks++; if ({game_over, ai_turn} !== 2'b10) begin n_fail++; $display("FAIL draw_no_ai_wait got=%b exp=10", {game_over, ai_turn}); end
  endtask

  task automatic test_ai_win;
    start_new_game;
    play(4); ai_reply(1);
    play(7); ai_reply(2);
    play(9); ai_reply(3);
    n_checks++; if (winner !== 2'b10) begin n_fail++; $display("FAIL aiwin_winner got=%b exp=10", winner); end
    n_checks++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL aiwin_game_over got=%b exp=1", game_over); end
    n_checks++; if (board !== 18'h1106A) begin n_fail++; $display("FAIL aiwin_board got=%h exp=%h", board, 18'h1106A); end
  endtask

  task automatic test_ai_err;
    start_new_game;
    play(5);
    ai_valid = 1'b1;
    ai_pos   = 4'd5;
    tick;
    tick;
    tick;
    n_checks++; if (ai_err !== 1'b0) begin n_fail++; $display("FAIL aierr_quiet_in_wait got=%b exp=0", ai_err); end
    tick;
    n_checks++; if (ai_err !== 1'b1) begin n_fail++; $display("FAIL aierr_occupied got=%b exp=1", ai_err); end
    n_checks++; if (board !== 18'h00100) begin n_fail++; $display("FAIL aierr_board got=%h exp=%h", board, 18'h00100); end
    ai_pos = 4'd0;
    tick;
    n_checks++; if ({ai_err, ai_turn} !== 2'b11) begin n_fail++; $display("FAIL aierr_pos0 got=%b exp=11", {ai_err, ai_turn}); end
    ai_valid = 1'b0;
    tick;
    n_checks++; if (ai_err !== 1'b0) begin n_fail++; $display("FAIL aierr_clears got=%b exp=0", ai_err); end
    ai_valid = 1'b1;
    ai_pos   = 4'd3;
    tick;
    ai_valid = 1'b0;
    n_checks++; if (board !== 18'h00120) begin n_fail++; $display("FAIL aierr_recover_board got=%h exp=%h", board, 18'h00120); end
    tick;
    n_checks++; if (p_ready !== 1'b1) begin n_fail++; $display("FAIL aierr_recover_ready got=%b exp=1", p_ready); end
  endtask

  task automatic test_ai_silence;
    start_new_game;
    play(1);
    ai_valid = 1'b0;
    repeat (3) tick;
`ifdef TTT_AI_TIMEOUT_EN
    repeat (7) tick;
    n_checks++; if ({fallback, ai_turn} !== 2'b01) begin n_fail++; $display("FAIL timeout_early got=%b exp=01", {fallback, ai_turn}); end
    n_checks++; if (board !== 18'h00001) begin n_fail++; $display("FAIL timeout_early_board got=%h exp=%h", board, 18'h00001); end
    tick;
    n_checks++; if (fallback !== 1'b1) begin n_fail++; $display("FAIL timeout_fallback got=%b exp=1", fallback); end
    n_checks++; if (board !== 18'h00009) begin n_fail++; $display("FAIL timeout_board got=%h exp=%h", board, 18'h00009); end
    tick;
    n_checks++; if ({fallback, p_ready} !== 2'b01) begin n_fail++; $display("FAIL timeout_after got=%b exp=01", {fallback, p_ready}); end
`else
    repeat (20) tick;
    n_checks++; if ({fallback, ai_turn} !== 2'b01) begin n_fail++; $display("FAIL wait_forever got=%b exp=01", {fallback, ai_turn}); end
    n_checks++; if (board !== 18'h00001) begin n_fail++; $display("FAIL wait_forever_board got=%h exp=%h", board, 18'h00001); end
`endif
  endtask

  task automatic test_reset_midgame;
    start_new_game;
    play(5);
    tick;
    n_checks++; if (ai_turn !== 1'b1) begin n_fail++; $display("FAIL midreset_pre got=%b exp=1", ai_turn); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (board !== 18'h0) begin n_fail++; $display("FAIL midreset_board got=%h exp=0", board); end
    n_checks++; if ({p_ready, ai_turn} !== 2'b10) begin n_fail++; $display("FAIL midreset_state got=%b exp=10", {p_ready, ai_turn}); end
    reset = 1'b0;
    tick;
    new_game = 1'b1;
    p_valid  = 1'b1;
    p_pos    = 4'd3;
    tick;
    new_game = 1'b0;
    p_valid  = 1'b0;
    n_checks++; if (board !== 18'h0) begin n_fail++; $display("FAIL ng_concurrent_board got=%h exp=0", board); end
    n_checks++; if (p_ready !== 1'b1) begin n_fail++; $display("FAIL ng_concurrent_ready got=%b exp=1", p_ready); end
    play(7);
    new_game = 1'b1;
    tick;
    new_game = 1'b0;
    n_checks++; if ({board, p_ready} !== {18'h0, 1'b1}) begin n_fail++; $display("FAIL ng_in_eval got=%h/%b exp=0/1", board, p_ready); end
  endtask

  initial begin
    reset    = 1'b1;
    new_game = 1'b0;
    p_valid  = 1'b0;
    p_pos    = 4'd0;
    ai_valid = 1'b0;
    ai_pos   = 4'd0;
    test_reset;
    test_basic_turn;
    test_illegal;
    test_player_win;
    test_draw;
    test_ai_win;
    test_ai_err;
    test_ai_silence;
    test_reset_midgame;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
